i2c_codec_target_model: RTL and testbench
=========================================

// Module: i2c_codec_target_model
// PURPOSE
// I2C target (slave) that answers the codec configuration master's bus traffic the way the ES7243E does.
// Oversamples SCL/SDA on clk_12M, decodes START/STOP, device address, register pointer and data bytes, and ACKs.
// Holds a 256x8 register file that the master can write and read back.
// Used as an on-board codec stand-in for bring-up and as the bus partner in configuration-master testbenches.
// PARAMETERS
// DEV_ADDR    7'h10  7-bit target address (write byte 8'h20, read byte 8'h21)
// FILTER_LEN  3      consecutive equal samples needed before a filtered SCL/SDA level changes (1..7)
// REG_INIT    8'h00  reset value of every register-file entry
// PORTS
// clk_12M     in   1  system clock, 12 MHz
// rstn        in   1  reset, synchronous, active-low
// i2c_sclk    in   1  I2C clock from the master (asynchronous)
// i2c_sdat    inout 1 I2C data, open-drain: driven 1'b0 or 1'bz only
// wr_strobe   out  1  one-cycle pulse when a data byte is committed to the register file
// wr_addr     out  8  register index of the last committed write
// wr_data     out  8  data of the last committed write
// wr_count    out  16 committed writes since reset, saturates at 16'hFFFF
// busy        out  1  high from START (address match) until STOP or return to IDLE
// dbg_addr    in   8  debug read index
// dbg_data    out  8  regs[dbg_addr], registered, 1-cycle latency
// BEHAVIOUR
// - Reset state: all outputs 0, i2c_sdat = z, FSM IDLE, pointer 0, all regs = REG_INIT.
// - rstn low mid-transfer releases SDA on the next clock and discards the partial byte.
// - Input path: 2-FF synchroniser, then a FILTER_LEN majority-free run filter.
// - A pulse shorter than FILTER_LEN clocks never changes the filtered level.
// - Edges are taken from the filtered levels: scl_rise, scl_fall.
// - START = filtered SDA 1->0 while SCL high. STOP = filtered SDA 0->1 while SCL high.
// - START and STOP are checked before bit sampling in the same cycle.
// - Bus timing: bits are sampled on scl_rise. The target changes SDA only on scl_fall.
// - Byte format: MSB first. Bit counter 0..8; count 8 is the ACK slot.
// - FSM states: IDLE, DEV, DEV_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE.
// - START in any state -> DEV (covers repeated start). STOP in any state -> IDLE and busy=0.
// - DEV: shift 8 bits.
//   - If [7:1]==DEV_ADDR: pull SDA low from the scl_fall after bit 8 to the scl_fall after the ACK clock, then go to DEV_ACK.
//   - Else -> IGNORE: SDA stays released (NACK), no state change until the next START/STOP.
// - DEV_ACK: R/W=0 -> PTR. R/W=1 -> RDATA, driving regs[ptr] bit7 on that same scl_fall.
// - PTR: 8 bits load the pointer, then ACK -> WDATA.
// - WDATA: after the 8th bit, regs[ptr]<=byte; wr_strobe/wr_addr/wr_data update one clock after the 8th scl_rise.
//   - Then ACK, ptr<=ptr+1 (wraps 8'hFF->8'h00), stay in WDATA.
// - RDATA: drive a 0 bit as SDA low and a 1 bit as z.
//   - After 8 bits release SDA and sample the master's ACK on the 9th scl_rise.
//   - ACK (0): ptr++, load next byte. NACK (1): RD_ACK, SDA released until START/STOP.
// - A write and a dbg read of the same index in the same cycle return the old value.
// - SDA output never drives 1; the target never stretches SCL.
// - Sizing: at 12 MHz and 100 kHz SCL each half-period is >=50 clocks, well above FILTER_LEN+2.
// TESTING
// - Write burst 20,01,3A + STOP -> three ACKs; regs[01]=3A; one wr_strobe with wr_addr=01, wr_data=3A; wr_count=1.
// - Write 20,FE,11,22,33 -> regs[FE]=11, regs[FF]=22, regs[00]=33 (pointer wrap); wr_count=3.
// - Address 28,01,55 -> NACK on the first byte; SDA never low; no wr_strobe; regs[01] unchanged.
// - Write 20,16,3F; then 20,16, Sr, 21, read 2 bytes ACK/NACK -> returns 3F, then regs[17]; SDA released after the NACK.
// - 2-clock low glitch on SCL during PTR (FILTER_LEN=3) -> ignored; pointer byte decoded correctly.
// - rstn low during the WDATA 5th bit -> SDA=z next clock, no write; a fresh 20,05,AA afterwards writes regs[05]=AA.

Source files
------------

// File: rtl/i2c_codec_target_model.sv
// ============================================================================
// i2c_codec_target_model
// ----------------------------------------------------------------------------
// I2C target that answers a codec configuration master the way the ES7243E
// does. SCL/SDA are oversampled on clk_12M, run through a synchroniser and a
// run-length filter, and START/STOP, the device address, the register pointer
// and data bytes are decoded from the filtered levels. A 256x8 register file
// can be written and read back by the master, and peeked through a debug port.
//
// Ports
//   clk_12M    in     1   system clock (12 MHz)
//   rstn       in     1   synchronous active-low reset
//   i2c_sclk   in     1   I2C clock from the master (asynchronous)
//   i2c_sdat   inout  1   I2C data, open-drain (driven 0 or z only)
//   wr_strobe  out    1   one-cycle pulse per byte committed to the register file
//   wr_addr    out    8   register index of the last committed write
//   wr_data    out    8   data of the last committed write
//   wr_count   out   16   committed writes since reset, saturating
//   busy       out    1   addressed transfer in progress (address match .. STOP)
//   dbg_addr   in     8   debug read index
//   dbg_data   out    8   regs[dbg_addr], registered, one-cycle latency
// ============================================================================
module i2c_codec_target_model #(
    parameter logic [6:0] DEV_ADDR   = 7'h10,
    parameter int         FILTER_LEN = 3,
    parameter logic [7:0] REG_INIT   = 8'h00
) (
    input  logic        clk_12M,
    input  logic        rstn,
    input  logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic        wr_strobe,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] wr_count,
    output logic        busy,
    input  logic [7:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    // Run counter width; FILTER_LEN is limited to 1..7.
    localparam int CW = 3;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RD_ACK,
        IGNORE
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------------
    // Input path: index 0 is SCL, index 1 is SDA.
    // ------------------------------------------------------------------------
    logic [1:0]    raw_in;
    logic [1:0]    sync_a, sync_b;
    logic [1:0]    filt, filt_q;
    logic [CW-1:0] run_cnt [2];

    assign raw_in = {i2c_sdat, i2c_sclk};

    // Synchroniser and filter idle high so that reset never looks like a
    // START or a falling SCL on an idle bus.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the
    // 2-FF synchroniser into a single stage.
    always_ff @(posedge clk_12M) begin
        if (!rstn) begin
            sync_a     <= 2'b11;
            sync_b     <= 2'b11;
            filt       <= 2'b11;
            filt_q     <= 2'b11;
            run_cnt[0] <= '0;
            run_cnt[1] <= '0;
        end else begin
            sync_a <= raw_in;
            sync_b <= sync_a;
            filt_q <= filt;
            // The filtered level flips only after FILTER_LEN consecutive
            // samples disagree with it; any agreeing sample restarts the run.
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == filt[i]) begin
                    run_cnt[i] <= '0;
                end else if (run_cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i]    <= sync_b[i];
                    run_cnt[i] <= '0;
                end else begin
                    run_cnt[i] <= run_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, scl_q, sda_f, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_f = filt[0];
    assign sda_f = filt[1];
    assign scl_q = filt_q[0];
    assign sda_q = filt_q[1];

    assign scl_rise  =  scl_f & ~scl_q;
    assign scl_fall  = ~scl_f &  scl_q;
    assign start_det =  scl_f &  scl_q &  sda_q & ~sda_f;
    assign stop_det  =  scl_f &  scl_q & ~sda_q &  sda_f;

    // ------------------------------------------------------------------------
    // Protocol datapath registers
    // ------------------------------------------------------------------------
    logic [3:0] bit_cnt;     // 0..7 data bits, 8 = ACK slot
    logic [7:0] shift;       // receive shifter, or transmit byte in RDATA
    logic [7:0] ptr;         // register pointer
    logic       sda_oe;      // 1 = pull SDA low
    logic [7:0] regs [256];
    logic [7:0] byte_in;
    logic       addr_match;

    assign byte_in    = {shift[6:0], sda_f};
    assign addr_match = (shift[7:1] == DEV_ADDR);

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_12M) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next state. START/STOP take priority over bit handling.
    // ------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before any branch;
    // a path that leaves one unassigned infers a latch.
    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = DEV;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                DEV:       if (scl_fall && bit_cnt == 4'd8)
                               state_nxt = addr_match ? DEV_ACK : IGNORE;
                DEV_ACK:   if (scl_fall) state_nxt = shift[0] ? RDATA : PTR;
                PTR:       if (scl_fall && bit_cnt == 4'd8) state_nxt = PTR_ACK;
                PTR_ACK:   if (scl_fall) state_nxt = WDATA;
                WDATA:     if (scl_fall && bit_cnt == 4'd8) state_nxt = WDATA_ACK;
                WDATA_ACK: if (scl_fall) state_nxt = WDATA;
                RDATA:     if (scl_rise && bit_cnt == 4'd8 && sda_f) state_nxt = RD_ACK;
                default:   state_nxt = state;  // IDLE, RD_ACK, IGNORE wait for START/STOP
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 3: action decode for the datapath
    // ------------------------------------------------------------------------
    logic on_bus;       // no START/STOP this cycle
    logic rx_state;     // states that shift in a byte from the master
    logic shift_en;     // capture one receive bit
    logic commit;       // 8th data bit of a write has just been captured
    logic ack_drive;    // start driving our ACK
    logic ack_done;     // end of the ACK clock we drove
    logic rd_shift;     // master clocked in one of our read bits
    logic rd_ack_rise;  // master's ACK/NACK after a read byte
    logic rd_fall;      // SCL fall inside a read byte
    logic load_rd;      // fetch regs[ptr] and present its MSB

    always_comb begin
        on_bus      = !(start_det || stop_det);
        rx_state    = (state == DEV) || (state == PTR) || (state == WDATA);
        shift_en    = on_bus && rx_state && scl_rise && (bit_cnt < 4'd8);
        commit      = shift_en && (state == WDATA) && (bit_cnt == 4'd7);
        ack_drive   = on_bus && rx_state && scl_fall && (bit_cnt == 4'd8)
                      && ((state != DEV) || addr_match);
        ack_done    = on_bus && scl_fall
                      && ((state == DEV_ACK) || (state == PTR_ACK) || (state == WDATA_ACK));
        rd_shift    = on_bus && (state == RDATA) && scl_rise && (bit_cnt < 4'd8);
        rd_ack_rise = on_bus && (state == RDATA) && scl_rise && (bit_cnt == 4'd8);
        rd_fall     = on_bus && (state == RDATA) && scl_fall;
        // A fall with bit_cnt==0 inside RDATA can only follow an ACKed byte.
        load_rd     = (ack_done && (state == DEV_ACK) && shift[0])
                      || (rd_fall && (bit_cnt == 4'd0));
    end

    // ------------------------------------------------------------------------
    // Datapath: bit counter, shifter, pointer, SDA drive, write reporting.
    // Later assignments in this block deliberately override earlier ones.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_12M) begin
        if (!rstn) begin
            bit_cnt   <= '0;
            shift     <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_count  <= '0;
        end else begin
            wr_strobe <= commit;

            if (!on_bus) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end
            if (stop_det) busy <= 1'b0;

            if (shift_en) begin
                shift   <= byte_in;
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (commit) begin
                wr_addr <= ptr;
                wr_data <= byte_in;
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end

            if (ack_drive) begin
                sda_oe <= 1'b1;
                if (state == PTR) ptr  <= shift;
                if (state == DEV) busy <= 1'b1;
            end

            if (ack_done) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                if (state == WDATA_ACK) ptr <= ptr + 8'd1;
            end

            if (rd_shift) begin
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
            end

            // Master ACK moves on to the next register; a NACK leaves ptr
            // alone and the FSM parks in RD_ACK with SDA already released.
            if (rd_ack_rise) begin
                bit_cnt <= '0;
                if (!sda_f) ptr <= ptr + 8'd1;
            end

            // Next read bit after each fall; release for the master's ACK.
            if (rd_fall && bit_cnt != 4'd0)
                sda_oe <= (bit_cnt == 4'd8) ? 1'b0 : ~shift[7];

            if (load_rd) begin
                shift  <= regs[ptr];
                sda_oe <= ~regs[ptr][7];
            end

            if ((state == IDLE) || (state == IGNORE) || (state == RD_ACK))
                sda_oe <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Register file and debug port
    // ------------------------------------------------------------------------
    // NOTE: this array is reset entry by entry, so it builds as flops rather
    // than a RAM macro; that is what gives every register a defined power-on
    // value matching the codec.
    always_ff @(posedge clk_12M) begin
        if (!rstn) begin
            for (int i = 0; i < 256; i++) regs[i] <= REG_INIT;
            dbg_data <= '0;
        end else begin
            if (commit) regs[ptr] <= byte_in;
            // Reads the pre-write contents when the same index is written.
            dbg_data <= regs[dbg_addr];
        end
    end

    // Open-drain pad: only ever pull low or release.
    assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_codec_target_model.sv
// ============================================================================
// tb_i2c_codec_target_model
// ----------------------------------------------------------------------------
// Directed bench for i2c_codec_target_model: a bit-banged I2C master with a
// pulled-up open-drain SDA, a table of write transactions with expected ACKs
// and write reports, a table of register read-backs through the debug port,
// and hand-written sequences for reads, SCL glitches and mid-transfer reset.
// ============================================================================
module tb_i2c_codec_target_model;

    localparam int H = 40;   // SCL half period in clk_12M cycles
    localparam int Q = 10;   // SDA change point after SCL falls

    logic        clk_12M  = 1'b0;
    logic        rstn     = 1'b0;
    logic        m_scl    = 1'b1;
    logic        m_sda    = 1'b1;   // 1 = release
    logic [7:0]  dbg_addr = 8'h00;
    wire         i2c_sdat;
    logic        wr_strobe;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] wr_count;
    logic        busy;
    logic [7:0]  dbg_data;

    pullup (i2c_sdat);
    assign i2c_sdat = m_sda ? 1'bz : 1'b0;

    always #5 clk_12M = ~clk_12M;

    i2c_codec_target_model #(
        .DEV_ADDR   (7'h10),
        .FILTER_LEN (3),
        .REG_INIT   (8'h00)
    ) dut (
        .clk_12M   (clk_12M),
        .rstn      (rstn),
        .i2c_sclk  (m_scl),
        .i2c_sdat  (i2c_sdat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_count  (wr_count),
        .busy      (busy),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Cycles with wr_strobe high, and cycles where the target holds SDA low
    // while the master has released it.
    int strobe_cnt  = 0;
    int tgt_low_cnt = 0;
    always @(negedge clk_12M) begin
        if (wr_strobe) strobe_cnt++;
        if (m_sda && i2c_sdat === 1'b0) tgt_low_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_12M);
    endtask

    // One SCL period, entered with SCL just low. Optional SCL low glitch of
    // 'glitch' clocks inside the high phase. 'seen' is the bus mid-high.
    task automatic clock_bit(input logic drive, input int glitch, output logic seen);
        wait_clk(Q);
        m_sda = drive;
        wait_clk(H - Q);
        m_scl = 1'b1;
        if (glitch > 0) begin
            wait_clk(H / 4);
            m_scl = 1'b0;
            wait_clk(glitch);
            m_scl = 1'b1;
            wait_clk(H / 4 - glitch);
        end else begin
            wait_clk(H / 2);
        end
        seen = (i2c_sdat !== 1'b0);
        wait_clk(H / 2);
        m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clk(Q);
        m_sda = 1'b1;
        wait_clk(H - Q);
        m_scl = 1'b1;
        wait_clk(H);
        m_sda = 1'b0;
        wait_clk(H);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q);
        m_sda = 1'b0;
        wait_clk(H - Q);
        m_scl = 1'b1;
        wait_clk(H);
        m_sda = 1'b1;
        wait_clk(H);
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], (i == glitch_bit) ? 2 : 0, s);
        clock_bit(1'b1, 0, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic master_ack_bit, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 0, s);
            b[i] = s;
        end
        clock_bit(master_ack_bit, 0, s);
    endtask

    task automatic dbg_read(input logic [7:0] a, output logic [7:0] d);
        dbg_addr = a;
        wait_clk(2);
        d = dbg_data;
    endtask

    // ------------------------------------------------------------------------
    // Vector tables
    // ------------------------------------------------------------------------
    typedef struct {
        int          n;            // bytes after START
        logic [39:0] bytes;        // first byte in [39:32]
        logic [4:0]  exp_ack;      // bit k = byte k ACKed
        logic        exp_drive;    // target pulls SDA low at some point
        int          exp_strobes;  // wr_strobe pulses in this transaction
        logic [15:0] exp_count;    // wr_count afterwards
        logic [7:0]  exp_waddr;
        logic [7:0]  exp_wdata;
    } tx_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } rb_t;

    tx_t tx [4];
    rb_t rb [7];

    initial begin
        logic       a;
        logic [7:0] d;
        logic [4:0] acks;
        int         low0, str0;

        tx[0] = '{n: 3, bytes: 40'h20_01_3A_00_00, exp_ack: 5'b00111, exp_drive: 1'b1,
                  exp_strobes: 1, exp_count: 16'd1, exp_waddr: 8'h01, exp_wdata: 8'h3A};
        tx[1] = '{n: 5, bytes: 40'h20_FE_11_22_33, exp_ack: 5'b11111, exp_drive: 1'b1,
                  exp_strobes: 3, exp_count: 16'd4, exp_waddr: 8'h00, exp_wdata: 8'h33};
        tx[2] = '{n: 3, bytes: 40'h28_01_55_00_00, exp_ack: 5'b00000, exp_drive: 1'b0,
                  exp_strobes: 0, exp_count: 16'd4, exp_waddr: 8'h00, exp_wdata: 8'h33};
        tx[3] = '{n: 4, bytes: 40'h20_16_3F_C5_00, exp_ack: 5'b01111, exp_drive: 1'b1,
                  exp_strobes: 2, exp_count: 16'd6, exp_waddr: 8'h17, exp_wdata: 8'hC5};

        rb[0] = '{addr: 8'h01, data: 8'h3A};
        rb[1] = '{addr: 8'hFE, data: 8'h11};
        rb[2] = '{addr: 8'hFF, data: 8'h22};
        rb[3] = '{addr: 8'h00, data: 8'h33};
        rb[4] = '{addr: 8'h16, data: 8'h3F};
        rb[5] = '{addr: 8'h17, data: 8'hC5};
        rb[6] = '{addr: 8'h02, data: 8'h00};

        // ---------------- reset state ----------------
        rstn = 1'b0;
        wait_clk(5);
        check("reset wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("reset wr_count",  {16'd0, wr_count},  32'd0);
        check("reset wr_addr",   {24'd0, wr_addr},   32'd0);
        check("reset wr_data",   {24'd0, wr_data},   32'd0);
        check("reset busy",      {31'd0, busy},      32'd0);
        check("reset dbg_data",  {24'd0, dbg_data},  32'd0);
        check("reset sda released", {31'd0, (i2c_sdat !== 1'b0)}, 32'd1);
        rstn = 1'b1;
        wait_clk(5);

        // ---------------- write transaction table ----------------
        for (int t = 0; t < 4; t++) begin
            low0 = tgt_low_cnt;
            str0 = strobe_cnt;
            acks = '0;
            i2c_start();
            for (int k = 0; k < tx[t].n; k++) begin
                write_byte(tx[t].bytes[39 - 8 * k -: 8], -1, a);
                acks[k] = a;
            end
            i2c_stop();
            wait_clk(4);
            check($sformatf("tx%0d acks", t), {27'd0, acks}, {27'd0, tx[t].exp_ack});
            check($sformatf("tx%0d sda driven", t), {31'd0, (tgt_low_cnt != low0)},
                  {31'd0, tx[t].exp_drive});
            check($sformatf("tx%0d strobes", t), strobe_cnt - str0, tx[t].exp_strobes);
            check($sformatf("tx%0d wr_count", t), {16'd0, wr_count}, {16'd0, tx[t].exp_count});
            check($sformatf("tx%0d wr_addr", t), {24'd0, wr_addr}, {24'd0, tx[t].exp_waddr});
            check($sformatf("tx%0d wr_data", t), {24'd0, wr_data}, {24'd0, tx[t].exp_wdata});
            check($sformatf("tx%0d busy after stop", t), {31'd0, busy}, 32'd0);
        end

        // ---------------- debug read-back table ----------------
        for (int r = 0; r < 7; r++) begin
            dbg_read(rb[r].addr, d);
            check($sformatf("regs[%02h]", rb[r].addr), {24'd0, d}, {24'd0, rb[r].data});
        end

        // ---------------- pointer set, repeated start, read 2 bytes ----------------
        i2c_start();
        write_byte(8'h20, -1, a);
        check("rd dev ack", {31'd0, a}, 32'd1);
        write_byte(8'h16, -1, a);
        check("rd ptr ack", {31'd0, a}, 32'd1);
        i2c_start();
        write_byte(8'h21, -1, a);
        check("rd read-addr ack", {31'd0, a}, 32'd1);
        read_byte(1'b0, d);
        check("rd byte0", {24'd0, d}, 32'h3F);
        read_byte(1'b1, d);
        check("rd byte1", {24'd0, d}, 32'hC5);
        check("rd busy before stop", {31'd0, busy}, 32'd1);
        low0 = tgt_low_cnt;
        wait_clk(2 * H);
        check("rd sda released after nack", tgt_low_cnt - low0, 0);
        i2c_stop();
        wait_clk(4);
        check("rd busy after stop", {31'd0, busy}, 32'd0);
        check("rd wr_count unchanged", {16'd0, wr_count}, 32'd6);

        // ---------------- 2-clock SCL glitch inside the pointer byte ----------------
        i2c_start();
        write_byte(8'h20, -1, a);
        write_byte(8'h5A, 3, a);
        check("glitch ptr ack", {31'd0, a}, 32'd1);
        write_byte(8'h77, -1, a);
        check("glitch data ack", {31'd0, a}, 32'd1);
        i2c_stop();
        wait_clk(4);
        dbg_read(8'h5A, d);
        check("glitch regs[5A]", {24'd0, d}, 32'h77);
        check("glitch wr_addr", {24'd0, wr_addr}, 32'h5A);

        // ---------------- reset while the target is ACKing ----------------
        i2c_start();
        for (int i = 7; i >= 0; i--) clock_bit(((8'h20 >> i) & 8'h01) != 0, 0, a);
        wait_clk(Q);
        m_sda = 1'b1;
        wait_clk(H - Q);
        m_scl = 1'b1;
        wait_clk(H / 2);
        check("ack-reset sda low before", {31'd0, (i2c_sdat === 1'b0)}, 32'd1);
        check("ack-reset busy before", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        wait_clk(1);
        check("ack-reset sda released next clk", {31'd0, (i2c_sdat !== 1'b0)}, 32'd1);
        wait_clk(3);
        rstn = 1'b1;
        wait_clk(H / 2);
        m_scl = 1'b0;
        i2c_stop();
        wait_clk(4);
        check("ack-reset busy", {31'd0, busy}, 32'd0);
        check("ack-reset wr_count", {16'd0, wr_count}, 32'd0);

        // ---------------- reset during the 5th data bit ----------------
        str0 = strobe_cnt;
        i2c_start();
        write_byte(8'h20, -1, a);
        write_byte(8'h05, -1, a);
        for (int i = 7; i >= 4; i--) clock_bit(((8'hAA >> i) & 8'h01) != 0, 0, a);
        wait_clk(Q);
        m_sda = 1'b1;              // bit 3 of 8'hAA
        wait_clk(H - Q);
        m_scl = 1'b1;
        wait_clk(H / 4);
        rstn = 1'b0;
        wait_clk(1);
        check("bit5-reset sda z", {31'd0, (i2c_sdat !== 1'b0)}, 32'd1);
        wait_clk(2);
        rstn = 1'b1;
        wait_clk(H / 4 - 3);
        m_scl = 1'b0;
        for (int i = 2; i >= 0; i--) clock_bit(((8'hAA >> i) & 8'h01) != 0, 0, a);
        clock_bit(1'b1, 0, a);
        i2c_stop();
        wait_clk(4);
        check("bit5-reset no strobe", strobe_cnt - str0, 0);
        check("bit5-reset wr_count", {16'd0, wr_count}, 32'd0);
        dbg_read(8'h05, d);
        check("bit5-reset regs[05]", {24'd0, d}, 32'h00);

        // Fresh write afterwards.
        acks = '0;
        i2c_start();
        write_byte(8'h20, -1, a);  acks[0] = a;
        write_byte(8'h05, -1, a);  acks[1] = a;
        write_byte(8'hAA, -1, a);  acks[2] = a;
        i2c_stop();
        wait_clk(4);
        check("fresh acks", {27'd0, acks}, 32'd7);
        check("fresh wr_count", {16'd0, wr_count}, 32'd1);
        check("fresh wr_data", {24'd0, wr_data}, 32'hAA);
        dbg_read(8'h05, d);
        check("fresh regs[05]", {24'd0, d}, 32'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
